// File: rtl/sy_tl_client_mux_pkg.sv
// Shared types for the client mux: FSM state encoding and index-width helper.
package sy_tl_client_mux_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } mux_state_e;

  // Index field is never narrower than one bit so a single master still has a slot.
  function automatic int unsigned sy_idx_wth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tl_pkg.sv
// TileLink-UL/UH A/D channel types and beat-count helpers.
// The source field is sized to hold the master index above the local id.
package tl_pkg;

  localparam int unsigned TL_SRC_W  = 8;
  localparam int unsigned TL_ADDR_W = 32;
  localparam int unsigned TL_DATA_W = 64;
  localparam int unsigned TL_MASK_W = TL_DATA_W / 8;

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_ARITH       = 3'd2;
  localparam logic [2:0] A_LOGIC       = 3'd3;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] A_INTENT      = 3'd5;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;
  localparam logic [2:0] D_GRANT           = 3'd4;
  localparam logic [2:0] D_GRANT_DATA      = 3'd5;
  localparam logic [2:0] D_RELEASE_ACK     = 3'd6;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [2:0]           param;
    logic [3:0]           size;
    logic [TL_SRC_W-1:0]  source;
    logic [TL_ADDR_W-1:0] address;
    logic [TL_MASK_W-1:0] mask;
    logic [TL_DATA_W-1:0] data;
    logic                 corrupt;
  } A_chan_bits_t;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [1:0]           param;
    logic [3:0]           size;
    logic [TL_SRC_W-1:0]  source;
    logic                 sink;
    logic                 denied;
    logic [TL_DATA_W-1:0] data;
    logic                 corrupt;
  } D_chan_bits_t;

  function automatic logic tl_a_has_data(input logic [2:0] opcode);
    return (opcode == A_PUT_FULL) || (opcode == A_PUT_PARTIAL) ||
           (opcode == A_ARITH) || (opcode == A_LOGIC);
  endfunction

  function automatic logic tl_d_has_data(input logic [2:0] opcode);
    return (opcode == D_ACCESS_ACK_DATA) || (opcode == D_GRANT_DATA);
  endfunction

  function automatic logic [15:0] tl_beats(input logic [3:0] size, input int unsigned data_bytes);
    logic [3:0] lg;
    lg = 4'($clog2(data_bytes));
    if (size > lg) return 16'd1 << (size - lg);
    return 16'd1;
  endfunction

endpackage

// File: rtl/sy_tl_client_mux_rr_arb.sv
// Round-robin arbiter: first masked request at or after ptr_i, or the locked
// index when lock_i is set (mask ignored so an open burst or stalled beat keeps its grant).
module sy_tl_rr_arb #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     mask_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             lock_i,
  input  logic [IDX_W-1:0] lock_idx_i,
  output logic             gnt_valid_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic [N-1:0]     gnt_oh_o
);

  int               c;
  logic [IDX_W-1:0] cidx;

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = lock_idx_i;
    gnt_oh_o    = '0;
    c           = 0;
    cidx        = '0;
    if (lock_i) begin
      gnt_valid_o = req_i[lock_idx_i];
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        c = int'(ptr_i) + k;
        if (c >= int'(N)) c = c - int'(N);
        cidx = IDX_W'(c);
        if (!gnt_valid_o && req_i[cidx] && mask_i[cidx]) begin
          gnt_valid_o = 1'b1;
          gnt_idx_o   = cidx;
        end
      end
    end
    if (gnt_valid_o) gnt_oh_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/sy_tl_client_mux.sv
// N-master to 1-slave TileLink-UL/UH A/D merger with burst lock and outstanding limits.
// Define SY_TL_MUX_A_SLICE_EN to insert a 2-entry skid buffer on the slave A side.
module sy_tl_client_mux
  import tl_pkg::*;
  import sy_tl_client_mux_pkg::*;
#(
  parameter int unsigned MASTER_NUM      = 2,
  parameter int unsigned SRC_WTH         = 4,
  parameter int unsigned DATA_BYTES      = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [MASTER_NUM-1:0]         m_A_valid_i,
  output logic [MASTER_NUM-1:0]         m_A_ready_o,
  input  A_chan_bits_t [MASTER_NUM-1:0] m_A_bits_i,
  output logic [MASTER_NUM-1:0]         m_D_valid_o,
  input  logic [MASTER_NUM-1:0]         m_D_ready_i,
  output D_chan_bits_t [MASTER_NUM-1:0] m_D_bits_o,
  output logic                          s_A_valid_o,
  input  logic                          s_A_ready_i,
  output A_chan_bits_t                  s_A_bits_o,
  input  logic                          s_D_valid_i,
  output logic                          s_D_ready_o,
  input  D_chan_bits_t                  s_D_bits_i,
  output logic                          busy_o
);

  localparam int unsigned IDX_WTH = sy_idx_wth(MASTER_NUM);
  localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);

  mux_state_e       state_q;
  logic [15:0]      beat_q;
  logic [15:0]      d_beat_q;
  logic [IDX_WTH-1:0] rr_q;
  logic [IDX_WTH-1:0] gidx_q;
  logic             stall_q;
  logic [CNT_W-1:0] cnt_q [MASTER_NUM];

  logic                  run;
  logic [MASTER_NUM-1:0] req;
  logic [MASTER_NUM-1:0] cnt_ok;
  logic [MASTER_NUM-1:0] gnt_oh;
  logic [MASTER_NUM-1:0] inc;
  logic [MASTER_NUM-1:0] dec;
  logic [IDX_WTH-1:0]    gnt_idx;
  logic [IDX_WTH-1:0]    rr_next;
  logic                  gnt_valid;
  logic                  lock;
  A_chan_bits_t          a_bits;
  logic                  a_ready;
  logic                  a_fire;
  logic                  a_last;
  logic [15:0]           beats_a;
  logic [IDX_WTH-1:0]    d_idx;
  logic                  d_bad;
  logic                  d_fire;
  logic                  d_first;
  logic                  d_last;
  logic [15:0]           beats_d;

  // Reset also gates the combinational paths so every handshake output reads 0 while held.
  assign run = rst_ni;
  assign req = m_A_valid_i & {MASTER_NUM{run}};

  always_comb begin
    for (int i = 0; i < int'(MASTER_NUM); i++)
      cnt_ok[i] = cnt_q[i] < CNT_W'(MAX_OUTSTANDING);
  end

  assign lock = (state_q == ST_BURST) || stall_q;

  sy_tl_rr_arb #(
    .N     (MASTER_NUM),
    .IDX_W (IDX_WTH)
  ) u_arb (
    .req_i       (req),
    .mask_i      (cnt_ok),
    .ptr_i       (rr_q),
    .lock_i      (lock),
    .lock_idx_i  (gidx_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx),
    .gnt_oh_o    (gnt_oh)
  );

  always_comb begin
    a_bits        = m_A_bits_i[gnt_idx];
    a_bits.source = '0;
    a_bits.source[SRC_WTH +: IDX_WTH] = gnt_idx;
    a_bits.source[SRC_WTH-1:0]        = m_A_bits_i[gnt_idx].source[SRC_WTH-1:0];
  end

  assign m_A_ready_o = gnt_oh & {MASTER_NUM{a_ready}};
  assign a_fire      = gnt_valid & a_ready;
  assign beats_a     = tl_a_has_data(a_bits.opcode) ? tl_beats(a_bits.size, DATA_BYTES) : 16'd1;
  assign a_last      = (state_q == ST_IDLE) ? (beats_a == 16'd1) : (beat_q == 16'd1);
  assign rr_next     = (gnt_idx == IDX_WTH'(MASTER_NUM - 1)) ? '0 : gnt_idx + IDX_WTH'(1);

`ifdef SY_TL_MUX_A_SLICE_EN
  A_chan_bits_t sk_q [2];
  logic [1:0]   sk_n_q;
  logic         sk_pop;

  assign a_ready     = run & (sk_n_q != 2'd2);
  assign s_A_valid_o = (sk_n_q != 2'd0);
  assign s_A_bits_o  = sk_q[0];
  assign sk_pop      = s_A_valid_o & s_A_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sk_q[0] <= '0;
      sk_q[1] <= '0;
      sk_n_q  <= 2'd0;
    end else begin
      case ({a_fire, sk_pop})
        2'b10: begin
          if (sk_n_q == 2'd0) sk_q[0] <= a_bits;
          else                sk_q[1] <= a_bits;
          sk_n_q <= sk_n_q + 2'd1;
        end
        2'b01: begin
          sk_q[0] <= sk_q[1];
          sk_n_q  <= sk_n_q - 2'd1;
        end
        2'b11: begin
          if (sk_n_q == 2'd1) begin
            sk_q[0] <= a_bits;
          end else begin
            sk_q[0] <= sk_q[1];
            sk_q[1] <= a_bits;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign a_ready     = run & s_A_ready_i;
  assign s_A_valid_o = gnt_valid;
  assign s_A_bits_o  = a_bits;
`endif

  assign d_idx       = s_D_bits_i.source[SRC_WTH +: IDX_WTH];
  assign d_bad       = int'(d_idx) >= int'(MASTER_NUM);
  assign s_D_ready_o = run & (d_bad | m_D_ready_i[d_idx]);
  assign d_fire      = s_D_valid_i & s_D_ready_o;
  assign d_first     = (d_beat_q == 16'd0);
  assign beats_d     = tl_d_has_data(s_D_bits_i.opcode) ? tl_beats(s_D_bits_i.size, DATA_BYTES) : 16'd1;
  assign d_last      = d_first ? (beats_d == 16'd1) : (d_beat_q == 16'd1);

  always_comb begin
    m_D_valid_o = '0;
    if (!d_bad) m_D_valid_o[d_idx] = s_D_valid_i & run;
    for (int i = 0; i < int'(MASTER_NUM); i++) begin
      m_D_bits_o[i]        = s_D_bits_i;
      m_D_bits_o[i].source = TL_SRC_W'(s_D_bits_i.source[SRC_WTH-1:0]);
    end
  end

  always_comb begin
    inc = '0;
    dec = '0;
    if (a_fire && a_last) inc[gnt_idx] = 1'b1;
    if (d_fire && d_last && !d_bad) dec[d_idx] = 1'b1;
  end

  always_comb begin
    busy_o = (state_q == ST_BURST);
    for (int i = 0; i < int'(MASTER_NUM); i++) busy_o = busy_o | (cnt_q[i] != '0);
  end

  // | state    | meaning                                             |
  // | ST_IDLE  | arbitrating per message; grant follows rr pointer   |
  // | ST_BURST | multi-beat A message open; grant locked to gidx_q   |
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      d_beat_q <= '0;
      rr_q     <= '0;
      gidx_q   <= '0;
      stall_q  <= 1'b0;
      for (int i = 0; i < int'(MASTER_NUM); i++) cnt_q[i] <= '0;
    end else begin
      gidx_q  <= gnt_idx;
      stall_q <= gnt_valid & ~a_ready;
      if (a_fire) begin
        case (state_q)
          ST_IDLE: begin
            if (beats_a != 16'd1) begin
              state_q <= ST_BURST;
              beat_q  <= beats_a - 16'd1;
            end
          end
          ST_BURST: begin
            beat_q <= beat_q - 16'd1;
            if (beat_q == 16'd1) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
        if (a_last) rr_q <= rr_next;
      end
      if (d_fire) begin
        if (d_first) begin
          if (beats_d != 16'd1) d_beat_q <= beats_d - 16'd1;
        end else begin
          d_beat_q <= d_beat_q - 16'd1;
        end
      end
      for (int i = 0; i < int'(MASTER_NUM); i++) begin
        if (inc[i] && !dec[i])      cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        else if (dec[i] && !inc[i]) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < int'(MASTER_NUM); g++) begin : g_cnt_chk
    a_no_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(inc[g] && !dec[g] && cnt_q[g] == CNT_W'(MAX_OUTSTANDING)));
    a_no_udf: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(dec[g] && !inc[g] && cnt_q[g] == '0));
  end

  a_d_idx_ok: assert property (@(posedge clk_i) disable iff (!rst_ni) !(s_D_valid_i && d_bad));

endmodule
